// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: access-size encodings,
// controller states and request legality helpers.
`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 12
`endif

package mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        MERGE  = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } mem_state_t;

    function automatic logic mem_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic r_mis;
        r_mis = 1'b0;
        case (funct3)
            MEM_H, MEM_HU: r_mis = addr_lo[0];
            MEM_W:         r_mis = (addr_lo != 2'b00);
            default:       r_mis = 1'b0;
        endcase
        return r_mis;
    endfunction

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic mem_funct3_legal(input logic we, input logic [2:0] funct3);
        logic r_ok;
        r_ok = 1'b0;
        case (funct3)
            MEM_B, MEM_H, MEM_W: r_ok = 1'b1;
            MEM_BU, MEM_HU:      r_ok = ~we;
            default:             r_ok = 1'b0;
        endcase
        return r_ok;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a RAM word and sign- or zero-extends it.
// Purely combinational so the instruction-fetch path can share it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension
    always_comb begin
        w_byte = 8'd0;
        w_half = 16'd0;
        o_data = 32'd0;
        case (i_addr_lo)
            2'b00:   w_byte = i_word[7:0];
            2'b01:   w_byte = i_word[15:8];
            2'b10:   w_byte = i_word[23:16];
            2'b11:   w_byte = i_word[31:24];
            default: w_byte = 8'd0;
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
        case (i_funct3)
            MEM_B:   o_data = {{24{w_byte[7]}}, w_byte};
            MEM_BU:  o_data = {24'd0, w_byte};
            MEM_H:   o_data = {{16{w_half[15]}}, w_half};
            MEM_HU:  o_data = {16'd0, w_half};
            MEM_W:   o_data = i_word;
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-wide RAM with one-cycle registered reads.
// Sub-word stores are done as read-modify-write since the RAM has no byte enables.
`ifndef RAM_ADDRESS_BITWIDTH
`define RAM_ADDRESS_BITWIDTH 12
`endif

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = `RAM_ADDRESS_BITWIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    mem_state_t        r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;
    logic [ADDR_W-1:0] r_ram_address;
    logic [31:0]       r_ram_wdata;

    logic              w_illegal;
    logic              w_word_store;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merge_word;

    assign w_illegal    = ~mem_funct3_legal(req_we, req_funct3) | mem_misaligned(req_funct3, req_addr[1:0]);
    assign w_word_store = r_we & (r_funct3 == MEM_W);

    // A write that coincides with reset is dropped by gating on rstn.
    assign ram_we      = rstn & (((r_state == ACCESS) & w_word_store) | (r_state == WRITE));
    assign ram_address = r_ram_address;
    assign ram_wdata   = r_ram_wdata;
    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;

    mem_load_align u_load_align (
        .i_word    (ram_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    // Merge the store data (still held in r_ram_wdata) into the word read back from RAM
    always_comb begin
        w_merge_word = ram_rdata;
        if (r_funct3 == MEM_H) begin
            if (r_addr_lo[1]) begin
                w_merge_word[31:16] = r_ram_wdata[15:0];
            end else begin
                w_merge_word[15:0] = r_ram_wdata[15:0];
            end
        end else begin
            case (r_addr_lo)
                2'b00:   w_merge_word[7:0]   = r_ram_wdata[7:0];
                2'b01:   w_merge_word[15:8]  = r_ram_wdata[7:0];
                2'b10:   w_merge_word[23:16] = r_ram_wdata[7:0];
                2'b11:   w_merge_word[31:24] = r_ram_wdata[7:0];
                default: w_merge_word        = ram_rdata;
            endcase
        end
    end

    // Transaction controller with registered handshake, response and RAM bus outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_funct3      <= 3'd0;
            r_addr_lo     <= 2'd0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= 32'd0;
            r_resp_err    <= 1'b0;
            r_ram_address <= '0;
            r_ram_wdata   <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we         <= req_we;
                        r_funct3     <= req_funct3;
                        r_addr_lo    <= req_addr[1:0];
                        r_req_ready  <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        if (w_illegal) begin
                            r_resp_err   <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_resp_err    <= 1'b0;
                            r_ram_address <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_we) begin
                                r_ram_wdata <= req_wdata;
                            end
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (w_word_store) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_state <= MERGE;
                    end
                end
                MERGE: begin
                    if (r_we) begin
                        r_ram_wdata <= w_merge_word;
                        r_state     <= WRITE;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side memory access unit between the CPU's memory stage and the word-organised data RAM. Accepts one load or store per valid/ready handshake and drives the RAM's `write_enable`, `address` and `write_data` pins. Handles the RAM's one-cycle registered-read latency. Implements byte and halfword stores as read-modify-write, because the RAM has no byte enables. Returns sign- or zero-extended load data, or a misalignment error, on a valid/ready response channel.

## Interface
Parameters:
- `ADDR_W`, default `` `RAM_ADDRESS_BITWIDTH ``, byte-address width.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rstn`  in  1  reset; synchronous, active-low. One clock; reset is synchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  access size/sign, RISC-V encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  32  load result; 0 for stores.
- `resp_err`  out  1  misaligned access or illegal funct3.
- `ram_we`  out  1  to RAM `write_enable`.
- `ram_address`  out  ADDR_W  to RAM `address`; bits [1:0] always 0.
- `ram_wdata`  out  32  to RAM `write_data`.
- `ram_rdata`  in  32  from RAM `data`. Valid in the cycle after `ram_address` was presented at a posedge.

## Operation
- State machine states: IDLE, ACCESS, MERGE, WRITE, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch we, funct3, addr and wdata.
  - Legality check on the incoming request:
    - H/HU requires addr[0] = 0.
    - W requires addr[1:0] = 0.
    - Stores allow only 000/001/010.
    - Loads allow only 000/001/010/100/101.
  - Illegal request → RESP with `resp_err`=1. No RAM access.
  - Legal request → ACCESS.
- **ACCESS**
  - `ram_address` = {addr[ADDR_W-1:2], 2'b00}.
  - Word store: `ram_we`=1, `ram_wdata`=wdata → RESP.
  - Anything else: `ram_we`=0 → MERGE.
- **MERGE** (`ram_rdata` valid this cycle)
  - Load: extract byte/half by addr[1:0]/addr[1], sign- or zero-extend, register into `resp_rdata` → RESP.
  - Sub-word store: register a merged word into `ram_wdata`. Byte lane addr[1:0] (SB) or half addr[1] (SH) is replaced by wdata[7:0]/[15:0]. → WRITE.
- **WRITE**: `ram_we`=1 with the merged word, same `ram_address` → RESP.
- **RESP**
  - `resp_valid`=1; `resp_rdata`/`resp_err` held stable.
  - Leave to IDLE when `resp_ready`=1.
  - `req_ready`=0. No new request is accepted in the same cycle the response is taken.
- `ram_we` is high only in ACCESS (word store) and WRITE. It is forced to 0 whenever `rstn`=0, so a write coinciding with reset is dropped.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready`=1 after reset.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `ram_we`=0, `ram_address`=0, `ram_wdata`=0.
- Latency from the accept edge (cycle 0) to the first `resp_valid` cycle:
  - Word store: 2.
  - Load: 3.
  - Byte/half store: 4.
  - Error: 1.
- Throughput: one transaction in flight. Back-to-back issue rate is latency + 1 cycles with `resp_ready` tied high.
- Reset mid-operation: state returns to IDLE at the next edge and any partial RMW is abandoned. The RAM word is unmodified if reset precedes the WRITE cycle.
- `resp_ready` low stalls RESP indefinitely with all outputs stable.
- `ram_address` and `ram_wdata` are registered; `ram_we` is state-decoded.

## Structure
- Shared package `mem_pkg`:
  - funct3 localparams `MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`.
  - State enum `mem_state_t`.
  - Function `mem_misaligned(funct3, addr[1:0])`.
- Sub-module `mem_load_align`: combinational; ram word + addr[1:0] + funct3 → extended 32-bit result. It is reused by the instruction-fetch path later.
- The store merge stays inline in `mem_access_unit`.

## Test plan
- **Word round trip:** SW 0xDEADBEEF @0x10 then LW @0x10 → `ram_we` pulse at address 0x10 cycle 1; load `resp_rdata`=0xDEADBEEF at cycle 3.
- **Sub-word stores:**
  - Preload 0x11223344 @0x20.
  - SB 0xAA @0x21 → exactly one `ram_we` pulse, with `ram_wdata`=0x1122AA44 in WRITE.
  - SH 0xBEEF @0x22 → 0xBEEFAA44.
- **Sign handling:** word 0x80FF7F01 @0x30.
  - LB @0x32 → 0xFFFFFFFF.
  - LBU @0x32 → 0x000000FF.
  - LH @0x32 → 0xFFFF80FF.
  - LHU @0x30 → 0x00007F01.
- **Errors:**
  - LW @0x31 → `resp_err`=1 at cycle 1, no `ram_we`.
  - SH @0x33 → same.
  - Store with funct3=100 → same.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles after a load → `resp_valid`, `resp_rdata` stable, `req_ready`=0. Release → IDLE next cycle.
- **Reset mid-RMW:** SB @0x21; drive `rstn`=0 in the MERGE cycle → no `ram_we` ever asserts. Word @0x20 is unchanged on readback; `req_ready`=1 after release.
